morra_match_driver: RTL and testbench
=====================================

Name: morra_match_driver

Overview:
- Initiator for the MorraCinese game core: drives PRIMO, SECONDO and INIZIA, and consumes MANCHE and PARTITA.
- Runs one complete match per start request: configures the round count, issues pseudo-random moves for both players, and tallies per-round results.
- Stops when PARTITA reports a final result or when the round budget runs out.
- Used as an on-chip self-play/stimulus engine and as a reusable bench driver.

Parameters:
- SEED_P, 8'hA5, LFSR seed for player 1 moves; 8'h00 is replaced by 8'h01.
- SEED_S, 8'h3C, LFSR seed for player 2 moves; 8'h00 is replaced by 8'h01.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a match; ignored unless the block is in IDLE.
- cfg_rounds  in  4  match length code; round count = cfg_rounds + 4 (range 4..19).
- MANCHE  in  2  round result: 00 invalid, 01 player 1 wins, 10 player 2 wins, 11 tie.
- PARTITA  in  2  match result: 00 ongoing, 01 player 1 wins, 10 player 2 wins, 11 draw.
- PRIMO  out  2  player 1 move (01 rock, 10 paper, 11 scissors); during INIZIA carries cfg_rounds[3:2].
- SECONDO  out  2  player 2 move; during INIZIA carries cfg_rounds[1:0].
- INIZIA  out  1  match (re)start strobe.
- busy  out  1  high from INIT through CHECK.
- done  out  1  one-cycle pulse when a match ends.
- winner  out  2  last sampled non-zero PARTITA; 00 on timeout.
- timeout  out  1  match ended because the round budget was exhausted.
- wins_p, wins_s, ties, invalids  out  5 each  per-match round tallies.
- mismatches  out  5  result-check error count (see Optional Feature).

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All outputs are 0.
  - LFSRs load their seeds.
  - Round counter clears.
  - Reset mid-match aborts the match immediately; no done pulse is produced.
- States: IDLE, INIT, PLAY, CHECK, FIN.
- IDLE:
  - Drives PRIMO=SECONDO=00 and INIZIA=0.
  - On start, captures cfg_rounds, clears all tallies, winner and timeout, then goes to INIT.
- INIT (exactly 1 cycle):
  - Drives INIZIA=1, PRIMO=cfg[3:2], SECONDO=cfg[1:0].
  - Clears the round counter, then goes to PLAY.
- PLAY (1 cycle):
  - Drives INIZIA=0.
  - Move from LFSR[1:0]; the value 00 is mapped to 01, so an issued move is never 00.
  - Both LFSRs advance.
  - Round counter increments (5-bit).
  - Goes to CHECK.
- CHECK (1 cycle):
  - Drives PRIMO=SECONDO=00; the core's result is registered with 1-cycle latency.
  - Samples MANCHE and increments exactly one tally: 01→wins_p, 10→wins_s, 11→ties, 00→invalids.
  - Tallies saturate at 31.
  - If PARTITA≠00: winner=PARTITA, go to FIN.
  - Else if the round counter equals cfg+4: timeout=1, winner=00, go to FIN.
  - Else go to PLAY.
  - When PARTITA≠00 coincides with the last budgeted round, PARTITA wins and timeout stays 0.
- FIN (1 cycle): done=1, busy=0, then IDLE.
- Tallies, winner and timeout hold until the next accepted start.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4, shift left, feedback into bit0.
  - Advances only in PLAY, so the move sequence is deterministic for a given seed.
- start asserted in any state other than IDLE has no effect.

Optional Feature:
- Macro: MORRA_RESULT_CHECK_EN.
- Defined:
  - In CHECK, the block computes the expected MANCHE from the moves it issued in the preceding PLAY (rock>scissors, scissors>paper, paper>rock, equal→11).
  - mismatches increments (saturating) when the sampled MANCHE differs.
- Undefined: the checker logic is absent and mismatches is tied to 0.

Decomposition:
- Package morra_pkg holds:
  - move_t {NONE=00, SASSO=01, CARTA=10, FORBICE=11};
  - result_t {INVALID=00, P1=01, P2=10, TIE=11};
  - the FSM state enum;
  - MIN_ROUNDS=4;
  - function expected_result(move_t, move_t).
- Sub-module: morra_lfsr8 (seed parameter, advance enable, 8-bit state out), instantiated twice.

Test Plan:
- Reset: assert rst 2 cycles → all outputs 0; start held low keeps INIZIA=0 indefinitely.
- Init encoding: start with cfg_rounds=4'b0001 → next cycle INIZIA=1, PRIMO=00, SECONDO=01, busy=1; following cycle INIZIA=0 with a non-00 move.
- Win: a bench model returns MANCHE=01 on 3 CHECKs with PARTITA=01 on the third → wins_p=3, winner=01, timeout=0, done pulses exactly once, busy falls.
- Timeout: cfg_rounds=0, MANCHE=11, PARTITA held 00 → exactly 4 PLAY cycles, ties=4, timeout=1, winner=00.
- Robustness:
  - start pulsed during PLAY is ignored;
  - rst asserted in CHECK returns to IDLE with tallies 0 and no done pulse;
  - MANCHE=00 increments invalids.
- MORRA_RESULT_CHECK_EN defined: model returns a wrong MANCHE on round 2 → mismatches=1; a correct model gives mismatches=0.

Source files
------------

// File: rtl/morra_pkg.sv
// morra_pkg: shared types, constants and the round-result rule for the
// MorraCinese match driver.
package morra_pkg;

    typedef enum logic [1:0] {
        NONE    = 2'b00,
        SASSO   = 2'b01,
        CARTA   = 2'b10,
        FORBICE = 2'b11
    } move_t;

    typedef enum logic [1:0] {
        INVALID = 2'b00,
        P1      = 2'b01,
        P2      = 2'b10,
        TIE     = 2'b11
    } result_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        PLAY  = 3'd2,
        CHECK = 3'd3,
        FIN   = 3'd4
    } state_t;

    localparam int MIN_ROUNDS = 4;

    // Round outcome as the core should report it for a pair of issued moves.
    function automatic result_t expected_result(input move_t p, input move_t s);
        if (p == NONE || s == NONE) return INVALID;
        if (p == s) return TIE;
        if ((p == SASSO   && s == FORBICE) ||
            (p == FORBICE && s == CARTA)   ||
            (p == CARTA   && s == SASSO)) return P1;
        return P2;
    endfunction

endpackage

// File: rtl/morra_lfsr8.sv
// morra_lfsr8: 8-bit Fibonacci LFSR (taps 8,6,5,4), shifts left with the
// feedback entering bit 0. A zero seed would lock up, so it is forced to 1.
module morra_lfsr8 #(
    parameter logic [7:0] SEED = 8'h01
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       advance,
    output logic [7:0] state
);

    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    logic fb;
    assign fb = state[7] ^ state[5] ^ state[4] ^ state[3];

    // Load the seed on reset, step only when asked.
    always_ff @(posedge clk) begin
        if (rst) state <= SEED_EFF;
        else if (advance) state <= {state[6:0], fb};
    end

endmodule

// File: rtl/morra_match_driver.sv
// morra_match_driver: runs one MorraCinese match per start request, issuing
// LFSR-driven moves for both players and tallying the core's round results.
// Defining MORRA_RESULT_CHECK_EN adds a checker that counts rounds where the
// core's MANCHE disagrees with the moves that were issued.
//
// state | meaning
// IDLE  | waiting for start, moves driven 00
// INIT  | INIZIA strobe, round count code on PRIMO/SECONDO
// PLAY  | issue one pair of moves, step LFSRs and round counter
// CHECK | sample MANCHE/PARTITA, decide on another round or finish
// FIN   | one-cycle done pulse, back to IDLE
module morra_match_driver
    import morra_pkg::*;
#(
    parameter logic [7:0] SEED_P = 8'hA5,
    parameter logic [7:0] SEED_S = 8'h3C
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] cfg_rounds,
    input  logic [1:0] MANCHE,
    input  logic [1:0] PARTITA,
    output logic [1:0] PRIMO,
    output logic [1:0] SECONDO,
    output logic       INIZIA,
    output logic       busy,
    output logic       done,
    output logic [1:0] winner,
    output logic       timeout,
    output logic [4:0] wins_p,
    output logic [4:0] wins_s,
    output logic [4:0] ties,
    output logic [4:0] invalids,
    output logic [4:0] mismatches
);

    state_t     state, state_nxt;
    logic [3:0] cfg_q;
    logic [4:0] round_cnt;
    logic [4:0] budget;
    logic [7:0] lfsr_p, lfsr_s;
    logic       advance;
    move_t      move_p, move_s;
    logic       last_round;
    logic       unused_lfsr_bits;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    assign advance = (state == PLAY);

    morra_lfsr8 #(.SEED(SEED_P)) u_lfsr_p (
        .clk    (clk),
        .rst    (rst),
        .advance(advance),
        .state  (lfsr_p)
    );

    morra_lfsr8 #(.SEED(SEED_S)) u_lfsr_s (
        .clk    (clk),
        .rst    (rst),
        .advance(advance),
        .state  (lfsr_s)
    );

    // Only the two low bits choose a move; the rest just feed the sequence.
    assign unused_lfsr_bits = ^{lfsr_p[7:2], lfsr_s[7:2]};

    // 00 is not a legal move, so it folds onto rock.
    assign move_p = (lfsr_p[1:0] == 2'b00) ? SASSO : move_t'(lfsr_p[1:0]);
    assign move_s = (lfsr_s[1:0] == 2'b00) ? SASSO : move_t'(lfsr_s[1:0]);

    assign budget     = {1'b0, cfg_q} + 5'(MIN_ROUNDS);
    assign last_round = (round_cnt == budget);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state decode and the core-facing / status outputs.
    always_comb begin
        state_nxt = state;
        PRIMO     = 2'b00;
        SECONDO   = 2'b00;
        INIZIA    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = INIT;
            end
            INIT: begin
                INIZIA    = 1'b1;
                PRIMO     = cfg_q[3:2];
                SECONDO   = cfg_q[1:0];
                busy      = 1'b1;
                state_nxt = PLAY;
            end
            PLAY: begin
                PRIMO     = move_p;
                SECONDO   = move_s;
                busy      = 1'b1;
                state_nxt = CHECK;
            end
            CHECK: begin
                busy = 1'b1;
                if (PARTITA != 2'b00 || last_round) state_nxt = FIN;
                else                                state_nxt = PLAY;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Match configuration, round counter, tallies and final result.
    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_q     <= '0;
            round_cnt <= '0;
            wins_p    <= '0;
            wins_s    <= '0;
            ties      <= '0;
            invalids  <= '0;
            winner    <= 2'b00;
            timeout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        cfg_q    <= cfg_rounds;
                        wins_p   <= '0;
                        wins_s   <= '0;
                        ties     <= '0;
                        invalids <= '0;
                        winner   <= 2'b00;
                        timeout  <= 1'b0;
                    end
                end
                INIT: round_cnt <= '0;
                PLAY: round_cnt <= round_cnt + 5'd1;
                CHECK: begin
                    case (MANCHE)
                        2'b01:   wins_p   <= sat_inc(wins_p);
                        2'b10:   wins_s   <= sat_inc(wins_s);
                        2'b11:   ties     <= sat_inc(ties);
                        default: invalids <= sat_inc(invalids);
                    endcase
                    // A real match result takes precedence over the budget.
                    if (PARTITA != 2'b00) begin
                        winner <= PARTITA;
                    end else if (last_round) begin
                        timeout <= 1'b1;
                        winner  <= 2'b00;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MORRA_RESULT_CHECK_EN
    move_t      move_p_q, move_s_q;
    logic [4:0] mism_q;

    // Remember the issued moves and compare the core's verdict against them.
    always_ff @(posedge clk) begin
        if (rst) begin
            move_p_q <= NONE;
            move_s_q <= NONE;
            mism_q   <= '0;
        end else begin
            if (state == IDLE && start) mism_q <= '0;
            if (state == PLAY) begin
                move_p_q <= move_p;
                move_s_q <= move_s;
            end
            if (state == CHECK && MANCHE != 2'(expected_result(move_p_q, move_s_q)))
                mism_q <= sat_inc(mism_q);
        end
    end

    assign mismatches = mism_q;
`else
    assign mismatches = 5'd0;
`endif

endmodule

// File: tb/tb_morra_match_driver.sv
// Directed bench for morra_match_driver with a small MorraCinese core model.
module tb_morra_match_driver;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] cfg_rounds = 4'd0;
    logic [1:0] MANCHE = 2'b00;
    logic [1:0] PARTITA = 2'b00;
    logic [1:0] PRIMO, SECONDO, winner;
    logic       INIZIA, busy, done, timeout;
    logic [4:0] wins_p, wins_s, ties, invalids, mismatches;

    int vectors = 0;
    int miscompares = 0;

    // core model configuration and bookkeeping
    logic [1:0] fixed_m = 2'b00;
    bit         use_rule = 1'b0;
    int         wrong_round = 0;
    int         partita_at = 0;
    logic [1:0] pval = 2'b00;
    int play_cnt = 0, done_cnt = 0, inizia_cnt = 0;
    int m_wp = 0, m_ws = 0, m_ti = 0, m_inv = 0, m_mism = 0;
    logic [7:0] lp = 8'hA5, ls = 8'h3C;

    morra_match_driver dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .cfg_rounds(cfg_rounds),
        .MANCHE    (MANCHE),
        .PARTITA   (PARTITA),
        .PRIMO     (PRIMO),
        .SECONDO   (SECONDO),
        .INIZIA    (INIZIA),
        .busy      (busy),
        .done      (done),
        .winner    (winner),
        .timeout   (timeout),
        .wins_p    (wins_p),
        .wins_s    (wins_s),
        .ties      (ties),
        .invalids  (invalids),
        .mismatches(mismatches)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [1:0] map_move(input logic [7:0] s);
        return (s[1:0] == 2'b00) ? 2'b01 : s[1:0];
    endfunction

    function automatic logic [1:0] rule(input logic [1:0] p, input logic [1:0] s);
        if (p == s) return 2'b11;
        if ((p == 2'b01 && s == 2'b11) || (p == 2'b11 && s == 2'b10) || (p == 2'b10 && s == 2'b01))
            return 2'b01;
        return 2'b10;
    endfunction

    // Core model: answers each PLAY with a registered MANCHE/PARTITA and
    // checks the issued moves against an independent LFSR model.
    initial begin
        logic [1:0] m, e;
        forever begin
            @(negedge clk);
            if (rst) begin
                lp = 8'hA5;
                ls = 8'h3C;
                MANCHE = 2'b00;
                PARTITA = 2'b00;
            end else begin
                if (done) done_cnt++;
                if (INIZIA) inizia_cnt++;
                if (!busy) begin
                    MANCHE = 2'b00;
                    PARTITA = 2'b00;
                end else if (!INIZIA && PRIMO != 2'b00) begin
                    play_cnt++;
                    check("move_p", PRIMO, map_move(lp));
                    check("move_s", SECONDO, map_move(ls));
                    lp = lfsr_next(lp);
                    ls = lfsr_next(ls);
                    e = rule(PRIMO, SECONDO);
                    m = use_rule ? e : fixed_m;
                    if (play_cnt == wrong_round) m = e + 2'd1;
                    if (m != e) m_mism++;
                    case (m)
                        2'b01:   m_wp++;
                        2'b10:   m_ws++;
                        2'b11:   m_ti++;
                        default: m_inv++;
                    endcase
                    MANCHE = m;
                    PARTITA = (play_cnt == partita_at) ? pval : 2'b00;
                end
            end
        end
    end

    task automatic model_setup(input logic [1:0] fm, input bit ur, input int wr,
                               input int pat, input logic [1:0] pv);
        fixed_m = fm; use_rule = ur; wrong_round = wr; partita_at = pat; pval = pv;
        play_cnt = 0; done_cnt = 0;
        m_wp = 0; m_ws = 0; m_ti = 0; m_inv = 0; m_mism = 0;
    endtask

    // Waits (bounded) for done; optionally pulses start on the Nth PLAY.
    task automatic wait_done(input int pulse_at);
        int  plays_seen = 0;
        bit  seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (start) start = 1'b0;
            if (busy && !INIZIA && PRIMO != 2'b00) begin
                plays_seen++;
                if (plays_seen == pulse_at) start = 1'b1;
            end
            if (done) seen = 1;
        end
        start = 1'b0;
        check("done_reached", seen, 1);
    endtask

    function automatic int exp_mism();
`ifdef MORRA_RESULT_CHECK_EN
        return m_mism;
`else
        return 0;
`endif
    endfunction

    typedef struct {
        logic [3:0] cfg;
        logic [1:0] manche;
        int         partita_at;
        logic [1:0] pval;
        int         pulse_at;
        int         plays, wp, ws, ti, inv;
        logic [1:0] win;
        logic       tmo;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{4'd0,  2'b11, 0,  2'b00, 0, 4,  0,  0, 4,  0, 2'b00, 1'b1};
        vecs[1] = '{4'd5,  2'b01, 3,  2'b01, 0, 3,  3,  0, 0,  0, 2'b01, 1'b0};
        vecs[2] = '{4'd1,  2'b10, 5,  2'b10, 0, 5,  0,  5, 0,  0, 2'b10, 1'b0};
        vecs[3] = '{4'd2,  2'b00, 0,  2'b00, 0, 6,  0,  0, 0,  6, 2'b00, 1'b1};
        vecs[4] = '{4'd15, 2'b11, 19, 2'b11, 0, 19, 0,  0, 19, 0, 2'b11, 1'b0};
        vecs[5] = '{4'd15, 2'b01, 0,  2'b00, 0, 19, 19, 0, 0,  0, 2'b00, 1'b1};
        vecs[6] = '{4'd0,  2'b11, 0,  2'b00, 2, 4,  0,  0, 4,  0, 2'b00, 1'b1};
        vecs[7] = '{4'd3,  2'b10, 1,  2'b01, 0, 1,  0,  1, 0,  0, 2'b01, 1'b0};

        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {PRIMO, SECONDO, INIZIA, busy, done, winner, timeout}, 0);
        check("rst_tallies", {wins_p, wins_s, ties, invalids, mismatches}, 0);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("idle_no_inizia", inizia_cnt, 0);
        check("idle_not_busy", busy, 0);

        // init encoding, then a 5-round tie match
        model_setup(2'b11, 0, 0, 0, 2'b00);
        cfg_rounds = 4'b0001;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("init_inizia", INIZIA, 1);
        check("init_primo", PRIMO, 0);
        check("init_secondo", SECONDO, 1);
        check("init_busy", busy, 1);
        @(negedge clk);
        check("play_inizia", INIZIA, 0);
        check("play_move_nonzero", (PRIMO != 2'b00) && (SECONDO != 2'b00), 1);
        wait_done(0);
        check("init_ties", ties, 5);
        check("init_timeout", timeout, 1);

        // table of whole matches
        for (int v = 0; v < 8; v++) begin
            model_setup(vecs[v].manche, 0, 0, vecs[v].partita_at, vecs[v].pval);
            @(negedge clk);
            cfg_rounds = vecs[v].cfg;
            start = 1'b1;
            wait_done(vecs[v].pulse_at);
            check($sformatf("v%0d_plays", v), play_cnt, vecs[v].plays);
            check($sformatf("v%0d_wins_p", v), wins_p, vecs[v].wp);
            check($sformatf("v%0d_wins_s", v), wins_s, vecs[v].ws);
            check($sformatf("v%0d_ties", v), ties, vecs[v].ti);
            check($sformatf("v%0d_invalids", v), invalids, vecs[v].inv);
            check($sformatf("v%0d_winner", v), winner, vecs[v].win);
            check($sformatf("v%0d_timeout", v), timeout, vecs[v].tmo);
            check($sformatf("v%0d_mism", v), mismatches, exp_mism());
            repeat (4) @(negedge clk);
            check($sformatf("v%0d_done_once", v), done_cnt, 1);
            check($sformatf("v%0d_busy_low", v), busy, 0);
            check($sformatf("v%0d_hold_winner", v), winner, vecs[v].win);
        end

        // reset in CHECK aborts without a done pulse
        model_setup(2'b01, 0, 0, 0, 2'b00);
        @(negedge clk);
        cfg_rounds = 4'd5;
        start = 1'b1;
        begin
            int checks = 0;
            for (int i = 0; i < 50 && checks < 2; i++) begin
                @(negedge clk);
                start = 1'b0;
                if (busy && !INIZIA && PRIMO == 2'b00) checks++;
            end
            check("abort_reached_check", checks, 2);
        end
        check("abort_pre_wins", wins_p, 1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_tallies", {wins_p, wins_s, ties, invalids, mismatches}, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_done", done_cnt, 0);
        check("abort_idle", busy, 0);

        // result checker: one wrong verdict, then an all-correct match
        model_setup(2'b00, 1, 2, 0, 2'b00);
        @(negedge clk);
        cfg_rounds = 4'd0;
        start = 1'b1;
        wait_done(0);
`ifdef MORRA_RESULT_CHECK_EN
        check("chk_wrong_mism", mismatches, 1);
`else
        check("chk_wrong_mism", mismatches, 0);
`endif
        check("chk_wrong_tallies", {wins_p, wins_s, ties, invalids}, {5'(m_wp), 5'(m_ws), 5'(m_ti), 5'(m_inv)});
        model_setup(2'b00, 1, 0, 0, 2'b00);
        @(negedge clk);
        start = 1'b1;
        wait_done(0);
        check("chk_good_mism", mismatches, 0);
        check("chk_good_tallies", {wins_p, wins_s, ties, invalids}, {5'(m_wp), 5'(m_ws), 5'(m_ti), 5'(m_inv)});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
